// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: synchroniser, stability counter, clean level and rise/fall pulses.
// Define DEBOUNCE_LONG_PRESS_EN to add per-channel long-hold detection on long_press.
module debounce_lane #(
  parameter int DELAY       = 20_000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT        = 1'b0,
  parameter int LONG_DELAY  = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic noisy,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic event_d
);
  localparam int CW = $clog2(DELAY + 1);
  localparam logic [CW-1:0] DMAX = CW'(DELAY);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic          prev_q, prev_d, clean_q, clean_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s, long_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], noisy};
    prev_d  = prev_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (s != prev_q) begin
      prev_d = s;
      cnt_d  = '0;
    end else if (cnt_q < DMAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      clean_d = prev_q;
    end
    // Pulses coincide with the cycle clean actually changes, so a change of s
    // in the same edge as saturation cannot produce an orphan pulse.
    rise_d = clean_d & ~clean_q;
    fall_d = ~clean_d & clean_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{INIT}};
      prev_q  <= INIT;
      clean_q <= INIT;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_DELAY + 1);
  localparam logic [HW-1:0] LMAX = HW'(LONG_DELAY);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q;

  // Counter sits at 0 while clean is low, so it is 0 in the rise cycle and
  // reaches LONG_DELAY exactly LONG_DELAY edges after rise.
  always_comb begin
    hold_d = hold_q;
    if (!clean_q)          hold_d = '0;
    else if (hold_q < LMAX) hold_d = hold_q + 1'b1;
    long_d = clean_q && (hold_q == LMAX - 1'b1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_d     = 1'b0;
  assign long_press = 1'b0;
`endif

  assign clean   = clean_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign event_d = rise_d | fall_d | long_d;
endmodule

module debounce_bank #(
  parameter int CHANNELS    = 4,
  parameter int DELAY       = 20_000,
  parameter int SYNC_STAGES = 2,
  parameter bit INIT        = 1'b0,
  parameter int LONG_DELAY  = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] noisy,
  output logic [CHANNELS-1:0] clean,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                any_event,
  output logic [CHANNELS-1:0] long_press
);
  logic [CHANNELS-1:0] event_d;
  logic                any_event_q, any_event_d;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    debounce_lane #(
      .DELAY(DELAY), .SYNC_STAGES(SYNC_STAGES), .INIT(INIT), .LONG_DELAY(LONG_DELAY)
    ) u_lane (
      .clk(clk), .rst(rst), .noisy(noisy[i]),
      .clean(clean[i]), .rise(rise[i]), .fall(fall[i]),
      .long_press(long_press[i]), .event_d(event_d[i])
    );
  end

  always_comb any_event_d = |event_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) any_event_q <= 1'b0;
    else     any_event_q <= any_event_d;
  end

  assign any_event = any_event_q;
endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank (CHANNELS=4, DELAY=4, SYNC_STAGES=2, LONG_DELAY=8).
module tb_debounce_bank;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif

  logic       clk, rst, any_event;
  logic [3:0] noisy, clean, rise, fall, long_press;
  int vectors = 0, miscompares = 0;

  debounce_bank #(.CHANNELS(4), .DELAY(4), .SYNC_STAGES(2), .INIT(1'b0), .LONG_DELAY(8)) dut (
    .clk(clk), .rst(rst), .noisy(noisy), .clean(clean), .rise(rise), .fall(fall),
    .any_event(any_event), .long_press(long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; noisy = 4'hF;
    repeat (3) tick();
    vectors++;
    if ({clean, rise, fall, any_event, long_press} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_state got clean=%b rise=%b fall=%b ev=%b lp=%b want all 0",
               clean, rise, fall, any_event, long_press);
    end
    noisy = 4'h0; rst = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      vectors++;
      if ({clean, rise, fall, any_event} !== 13'd0) begin
        miscompares++;
        $display("FAIL reset_idle e=%0d got clean=%b rise=%b fall=%b ev=%b want 0",
                 e, clean, rise, fall, any_event);
      end
    end
  endtask

  task automatic test_clean_press();
    noisy[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (rise[0] !== (e == 7) || clean[0] !== (e >= 7) || any_event !== (e == 7) || fall[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL press e=%0d got rise0=%b clean0=%b ev=%b fall0=%b want %b %b %b 0",
                 e, rise[0], clean[0], any_event, fall[0], e == 7, e >= 7, e == 7);
      end
    end
    noisy[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if (fall[0] !== (e == 7) || clean[0] !== (e < 7) || rise[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL release e=%0d got fall0=%b clean0=%b rise0=%b want %b %b 0",
                 e, fall[0], clean[0], rise[0], e == 7, e < 7);
      end
    end
  endtask

  task automatic test_glitch();
    // 4 sampled-high cycles: never reaches the stability threshold
    for (int e = 0; e < 20; e++) begin
      noisy[1] = (e < 4);
      tick();
      vectors++;
      if (clean[1] !== 1'b0 || rise[1] !== 1'b0 || fall[1] !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch4 e=%0d got clean1=%b rise1=%b fall1=%b want 0 0 0",
                 e, clean[1], rise[1], fall[1]);
      end
    end
    // 6 sampled-high cycles: s is seen high at edges 2..7, enough to latch
    for (int e = 0; e < 21; e++) begin
      noisy[1] = (e < 6);
      tick();
      vectors++;
      if (rise[1] !== (e == 7) || fall[1] !== (e == 13) || clean[1] !== (e >= 7 && e < 13)) begin
        miscompares++;
        $display("FAIL glitch6 e=%0d got rise1=%b fall1=%b clean1=%b want %b %b %b",
                 e, rise[1], fall[1], clean[1], e == 7, e == 13, e >= 7 && e < 13);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] exp_r;
    noisy[3:2] = 2'b11;
    for (int e = 0; e < 10; e++) begin
      tick();
      exp_r = (e == 7) ? 4'b1100 : 4'b0000;
      vectors++;
      if (rise !== exp_r || any_event !== (e == 7)) begin
        miscompares++;
        $display("FAIL simul e=%0d got rise=%b ev=%b want %b %b", e, rise, any_event, exp_r, e == 7);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_r, exp_c;
    noisy = 4'b1101;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    vectors++;
    if (clean !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || any_event !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async got clean=%b rise=%b fall=%b ev=%b want 0", clean, rise, fall, any_event);
    end
    @(posedge clk); #1;
    vectors++;
    if (clean !== 4'b0 || rise !== 4'b0 || fall !== 4'b0 || any_event !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_held got clean=%b rise=%b fall=%b ev=%b want 0", clean, rise, fall, any_event);
    end
    rst = 1'b0;
    for (int e = 6; e < 17; e++) begin
      tick();
      exp_r = (e == 13) ? 4'b1101 : 4'b0000;
      exp_c = (e >= 13) ? 4'b1101 : 4'b0000;
      vectors++;
      if (rise !== exp_r || clean !== exp_c || fall !== 4'b0) begin
        miscompares++;
        $display("FAIL rst_mid e=%0d got rise=%b clean=%b fall=%b want %b %b 0000",
                 e, rise, clean, fall, exp_r, exp_c);
      end
    end
  endtask

  task automatic test_long_press();
    logic [3:0] exp_lp;
    noisy = 4'b0000;
    repeat (20) tick();
    for (int p = 0; p < 2; p++) begin
      noisy[0] = 1'b1;
      for (int e = 0; e < 31; e++) begin
        tick();
        exp_lp = (LP && e == 15) ? 4'b0001 : 4'b0000;
        vectors++;
        if (rise[0] !== (e == 7) || long_press !== exp_lp || any_event !== (e == 7 || (LP && e == 15))) begin
          miscompares++;
          $display("FAIL long p=%0d e=%0d got rise0=%b lp=%b ev=%b want %b %b %b",
                   p, e, rise[0], long_press, any_event, e == 7, exp_lp, e == 7 || (LP && e == 15));
        end
      end
      noisy[0] = 1'b0;
      repeat (14) tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    noisy = 4'h0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    test_long_press();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
